// File: rtl/gear_pkg.sv
// Shared types and constants for the multi-leg landing gear controller.
package gear_pkg;

  typedef enum logic [2:0] {
    TAXI    = 3'd0,
    TAKEOFF = 3'd1,
    GOUP    = 3'd2,
    GODN    = 3'd3,
    FLYUP   = 3'd4,
    FLYDN   = 3'd5,
    FAULT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    F_NONE   = 2'd0,
    F_SENSOR = 2'd1,
    F_UP_TMO = 2'd2,
    F_DN_TMO = 2'd3
  } fault_t;

  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;
  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  typedef struct packed {
    logic red;
    logic grn;
    logic valve;
    logic pump;
    logic fault;
  } lamp_t;

  // Moore output decode; unknown encodings look like FAULT so the gear is driven down.
  function automatic lamp_t decode_lamps(state_t s);
    lamp_t l;
    case (s)
      TAXI:    l = '{red: OFF, grn: ON,  valve: DOWN, pump: OFF, fault: OFF};
      TAKEOFF: l = '{red: OFF, grn: ON,  valve: DOWN, pump: OFF, fault: OFF};
      GOUP:    l = '{red: ON,  grn: OFF, valve: UP,   pump: ON,  fault: OFF};
      GODN:    l = '{red: ON,  grn: OFF, valve: DOWN, pump: ON,  fault: OFF};
      FLYUP:   l = '{red: OFF, grn: OFF, valve: UP,   pump: OFF, fault: OFF};
      FLYDN:   l = '{red: OFF, grn: ON,  valve: DOWN, pump: OFF, fault: OFF};
      FAULT:   l = '{red: ON,  grn: OFF, valve: DOWN, pump: ON,  fault: ON};
      default: l = '{red: ON,  grn: OFF, valve: DOWN, pump: ON,  fault: ON};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/gear_fsm_assertions.sv
// Legal-predecessor checks for every controller state.
module gear_fsm_assertions
  import gear_pkg::*;
(
  input logic   clk_i,
  input logic   rst_ni,
  input state_t state_i
);

  a_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    state_i inside {TAXI, TAKEOFF, GOUP, GODN, FLYUP, FLYDN, FAULT});

  a_taxi: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == TAXI) |-> ($past(state_i) inside {TAXI, TAKEOFF, GODN, FLYDN, FAULT}));

  a_takeoff: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == TAKEOFF) |-> ($past(state_i) inside {TAXI, TAKEOFF}));

  a_goup: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == GOUP) |-> ($past(state_i) inside {TAKEOFF, GOUP, FLYDN}));

  a_godn: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == GODN) |-> ($past(state_i) inside {GOUP, GODN, FLYUP, FAULT}));

  a_flyup: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == FLYUP) |-> ($past(state_i) inside {GOUP, FLYUP}));

  a_flydn: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == FLYDN) |-> ($past(state_i) inside {TAKEOFF, GODN, FLYDN, FAULT}));

  // Sensor conflicts can push any state into FAULT.
  a_fault: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == FAULT) |->
      ($past(state_i) inside {TAXI, TAKEOFF, GOUP, GODN, FLYUP, FLYDN, FAULT}));

endmodule

// File: rtl/gear_timer.sv
// Saturating cycle counter; the owning FSM performs the terminal compares.
module gear_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [TIMER_W-1:0] count_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multi_gear_controller.sv
// Supervises NUM_GEAR gear legs with one shared valve/pump, takeoff delay,
// transit watchdog, in-transit reversal and a latched fault state.
module multi_gear_controller
  import gear_pkg::*;
#(
  parameter int unsigned NUM_GEAR       = 3,
  parameter int unsigned TAKEOFF_CYCLES = 2000,
  parameter int unsigned TRANSIT_CYCLES = 8000,
  parameter int unsigned TIMER_W        = 16
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                PlaneOnGround,
  input  logic                PilotLever,
  input  logic [NUM_GEAR-1:0] GearIsDown,
  input  logic [NUM_GEAR-1:0] GearIsUp,
  input  logic                FaultAck,
  output logic                RedLED,
  output logic                GrnLED,
  output logic                Valve,
  output logic                Pump,
  output logic                FaultLED,
  output logic [1:0]          FaultCode,
  output state_t              State
);

  localparam int unsigned     LongestWait = (TAKEOFF_CYCLES > TRANSIT_CYCLES) ?
                                            TAKEOFF_CYCLES : TRANSIT_CYCLES;
  localparam longint unsigned TimerSpan   = 64'(1) << TIMER_W;
  localparam logic [TIMER_W-1:0] TakeoffLast = TIMER_W'(TAKEOFF_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TransitLast = TIMER_W'(TRANSIT_CYCLES - 1);

  if ((NUM_GEAR < 1) || (NUM_GEAR > 8)) begin : g_bad_num_gear
    $error("NUM_GEAR must lie in 1..8");
  end
  if (TimerSpan <= 64'(LongestWait)) begin : g_bad_timer_w
    $error("TIMER_W too narrow for the takeoff/transit cycle counts");
  end

  state_t             state_q, state_d;
  fault_t             fault_q, fault_d;
  lamp_t              lamps_q;
  logic [TIMER_W-1:0] count;
  logic               all_down, all_up, conflict;
  logic               timer_clr, timer_en;

  assign all_down = &GearIsDown;
  assign all_up   = &GearIsUp;
  assign conflict = |(GearIsDown & GearIsUp);

  // Next-state logic: a sensor conflict outranks every state-specific rule.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if ((state_q != FAULT) && conflict) begin
      state_d = FAULT;
      fault_d = F_SENSOR;
    end else begin
      case (state_q)
        TAXI: begin
          if (!PlaneOnGround) state_d = TAKEOFF;
        end
        TAKEOFF: begin
          if (PlaneOnGround) begin
            state_d = TAXI;
          end else if (count == TakeoffLast) begin
            state_d = (PilotLever == UP) ? GOUP : FLYDN;
          end
        end
        GOUP: begin
          if (all_up) begin
            state_d = FLYUP;
          end else if (PilotLever == DOWN) begin
            state_d = GODN;
          end else if (count == TransitLast) begin
            state_d = FAULT;
            fault_d = F_UP_TMO;
          end
        end
        GODN: begin
          if (all_down && PlaneOnGround) begin
            state_d = TAXI;
          end else if (all_down) begin
            state_d = FLYDN;
          end else if (count == TransitLast) begin
            state_d = FAULT;
            fault_d = F_DN_TMO;
          end
        end
        FLYUP: begin
          if (PilotLever == DOWN) state_d = GODN;
        end
        FLYDN: begin
          if (PlaneOnGround) begin
            state_d = TAXI;
          end else if (PilotLever == UP) begin
            state_d = GOUP;
          end
        end
        FAULT: begin
          if (FaultAck && !conflict) begin
            fault_d = F_NONE;
            if (all_down && PlaneOnGround) begin
              state_d = TAXI;
            end else if (all_down) begin
              state_d = FLYDN;
            end else begin
              state_d = GODN;
            end
          end
        end
        default: begin
          state_d = FAULT;
          fault_d = F_SENSOR;
        end
      endcase
    end
  end

  // Timer restarts on any state change and idles at zero outside the timed states.
  assign timer_en  = state_q inside {TAKEOFF, GOUP, GODN};
  assign timer_clr = (state_d != state_q) || !timer_en;

  gear_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk_i   (Clock),
    .rst_ni  (Clear),
    .clr_i   (timer_clr),
    .en_i    (timer_en),
    .count_o (count)
  );

  // Lamps are registered from the next state so they track State exactly.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= TAXI;
      fault_q <= F_NONE;
      lamps_q <= decode_lamps(TAXI);
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      lamps_q <= decode_lamps(state_d);
    end
  end

  assign State     = state_q;
  assign FaultCode = 2'(fault_q);
  assign RedLED    = lamps_q.red;
  assign GrnLED    = lamps_q.grn;
  assign Valve     = lamps_q.valve;
  assign Pump      = lamps_q.pump;
  assign FaultLED  = lamps_q.fault;

  gear_fsm_assertions u_assertions (
    .clk_i   (Clock),
    .rst_ni  (Clear),
    .state_i (state_q)
  );

endmodule

// File: tb/tb_multi_gear_controller.sv
// Directed scenarios plus a randomized run against a behavioural gear model.
module tb_multi_gear_controller;
  import gear_pkg::*;

  localparam int unsigned NG = 3;
  localparam int unsigned TK = 4;
  localparam int unsigned TR = 8;
  localparam int unsigned TW = 4;

  logic          Clock = 1'b0;
  logic          Clear = 1'b1;
  logic          ground, lever, ack;
  logic [NG-1:0] dn, up;
  logic          RedLED, GrnLED, Valve, Pump, FaultLED;
  logic [1:0]    FaultCode;
  state_t        State;

  int n_checks = 0;
  int n_fail   = 0;

  state_t     m_state;
  int         m_cnt;
  logic [1:0] m_code;

  multi_gear_controller #(
    .NUM_GEAR(NG), .TAKEOFF_CYCLES(TK), .TRANSIT_CYCLES(TR), .TIMER_W(TW)
  ) dut (
    .Clock(Clock), .Clear(Clear), .PlaneOnGround(ground), .PilotLever(lever),
    .GearIsDown(dn), .GearIsUp(up), .FaultAck(ack),
    .RedLED(RedLED), .GrnLED(GrnLED), .Valve(Valve), .Pump(Pump),
    .FaultLED(FaultLED), .FaultCode(FaultCode), .State(State)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // Observed snapshot: {state, red, grn, valve, pump, fault_led, code}.
  function automatic logic [9:0] snap();
    return {3'(State), RedLED, GrnLED, Valve, Pump, FaultLED, FaultCode};
  endfunction

  // Expected snapshot from the lamp table for a state.
  function automatic logic [9:0] want(state_t s, logic [1:0] code);
    logic [4:0] l;
    case (s)
      GOUP:    l = 5'b10010;
      GODN:    l = 5'b10110;
      FLYUP:   l = 5'b00000;
      FAULT:   l = 5'b10111;
      default: l = 5'b01100;
    endcase
    return {3'(s), l, code};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Behavioural model: one clock of the gear rules, m_cnt = cycles already spent in m_state.
  task automatic model_step();
    state_t     nx = m_state;
    logic [1:0] nc = m_code;
    bit alld = &dn;
    bit allu = &up;
    bit conf = |(dn & up);
    if (m_state != FAULT && conf) begin
      nx = FAULT; nc = 2'd1;
    end else if (m_state == TAXI) begin
      if (!ground) nx = TAKEOFF;
    end else if (m_state == TAKEOFF) begin
      if (ground) nx = TAXI;
      else if (m_cnt + 1 == TK) nx = lever ? FLYDN : GOUP;
    end else if (m_state == GOUP) begin
      if (allu) nx = FLYUP;
      else if (lever) nx = GODN;
      else if (m_cnt + 1 == TR) begin nx = FAULT; nc = 2'd2; end
    end else if (m_state == GODN) begin
      if (alld) nx = ground ? TAXI : FLYDN;
      else if (m_cnt + 1 == TR) begin nx = FAULT; nc = 2'd3; end
    end else if (m_state == FLYUP) begin
      if (lever) nx = GODN;
    end else if (m_state == FLYDN) begin
      if (ground) nx = TAXI;
      else if (!lever) nx = GOUP;
    end else begin
      if (ack && !conf) begin
        nc = 2'd0;
        nx = !alld ? GODN : (ground ? TAXI : FLYDN);
      end
    end
    if (nx != m_state || !(nx inside {TAKEOFF, GOUP, GODN})) m_cnt = 0;
    else if (m_cnt < (1 << TW) - 1) m_cnt = m_cnt + 1;
    m_state = nx;
    m_code  = nc;
  endtask

  task automatic test_reset();
    ground = 1'b1; lever = 1'b1; dn = 3'b111; up = 3'b000; ack = 1'b0;
    #1 Clear = 1'b0;
    #1;
    n_checks++;
    if (snap() !== want(TAXI, 2'd0)) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", snap(), want(TAXI, 2'd0));
    end
    @(negedge Clock);
    Clear = 1'b1;
    tick();
    n_checks++;
    if (snap() !== want(TAXI, 2'd0)) begin
      n_fail++; $display("FAIL reset_hold_taxi: got %h want %h", snap(), want(TAXI, 2'd0));
    end
  endtask

  task automatic test_normal_cycle();
    ground = 1'b0; lever = UP;
    tick();
    for (int i = 0; i < int'(TK); i++) begin
      n_checks++;
      if (snap() !== want(TAKEOFF, 2'd0)) begin
        n_fail++; $display("FAIL takeoff_wait_%0d: got %h want %h", i, snap(), want(TAKEOFF, 2'd0));
      end
      tick();
    end
    n_checks++;
    if (snap() !== want(GOUP, 2'd0)) begin
      n_fail++; $display("FAIL normal_goup: got %h want %h", snap(), want(GOUP, 2'd0));
    end
    dn = 3'b000; up = 3'b111;
    tick();
    n_checks++;
    if (snap() !== want(FLYUP, 2'd0)) begin
      n_fail++; $display("FAIL normal_flyup: got %h want %h", snap(), want(FLYUP, 2'd0));
    end
  endtask

  task automatic test_extend_land();
    lever = DOWN;
    tick();
    n_checks++;
    if (snap() !== want(GODN, 2'd0)) begin
      n_fail++; $display("FAIL extend_godn: got %h want %h", snap(), want(GODN, 2'd0));
    end
    up = 3'b000; dn = 3'b111;
    tick();
    n_checks++;
    if (snap() !== want(FLYDN, 2'd0)) begin
      n_fail++; $display("FAIL extend_flydn: got %h want %h", snap(), want(FLYDN, 2'd0));
    end
    ground = 1'b1;
    tick();
    n_checks++;
    if (snap() !== want(TAXI, 2'd0)) begin
      n_fail++; $display("FAIL land_taxi: got %h want %h", snap(), want(TAXI, 2'd0));
    end
  endtask

  task automatic test_reversal();
    ground = 1'b0; lever = UP; dn = 3'b000; up = 3'b000;
    repeat (1 + TK) tick();
    n_checks++;
    if (snap() !== want(GOUP, 2'd0)) begin
      n_fail++; $display("FAIL reversal_goup: got %h want %h", snap(), want(GOUP, 2'd0));
    end
    up = 3'b011;
    repeat (3) tick();
    lever = DOWN;
    tick();
    n_checks++;
    if (snap() !== want(GODN, 2'd0)) begin
      n_fail++; $display("FAIL reversal_godn: got %h want %h", snap(), want(GODN, 2'd0));
    end
  endtask

  // Starts in GODN entered by reversal, so the full budget also proves the counter restarted.
  task automatic test_timeout();
    up = 3'b000; dn = 3'b101;
    for (int i = 0; i < int'(TR) - 1; i++) begin
      tick();
      n_checks++;
      if (snap() !== want(GODN, 2'd0)) begin
        n_fail++; $display("FAIL timeout_wait_%0d: got %h want %h", i, snap(), want(GODN, 2'd0));
      end
    end
    tick();
    n_checks++;
    if (snap() !== want(FAULT, 2'd3)) begin
      n_fail++; $display("FAIL timeout_fault: got %h want %h", snap(), want(FAULT, 2'd3));
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (snap() !== want(GODN, 2'd0)) begin
      n_fail++; $display("FAIL timeout_ack_godn: got %h want %h", snap(), want(GODN, 2'd0));
    end
    dn = 3'b111;
    tick();
    n_checks++;
    if (snap() !== want(FLYDN, 2'd0)) begin
      n_fail++; $display("FAIL timeout_recover_flydn: got %h want %h", snap(), want(FLYDN, 2'd0));
    end
  endtask

  task automatic test_conflict();
    up = 3'b010;
    tick();
    n_checks++;
    if (snap() !== want(FAULT, 2'd1)) begin
      n_fail++; $display("FAIL conflict_fault: got %h want %h", snap(), want(FAULT, 2'd1));
    end
    ack = 1'b1;
    tick();
    n_checks++;
    if (snap() !== want(FAULT, 2'd1)) begin
      n_fail++; $display("FAIL conflict_ack_ignored: got %h want %h", snap(), want(FAULT, 2'd1));
    end
    up = 3'b000;
    tick();
    ack = 1'b0;
    n_checks++;
    if (snap() !== want(FLYDN, 2'd0)) begin
      n_fail++; $display("FAIL conflict_exit_flydn: got %h want %h", snap(), want(FLYDN, 2'd0));
    end
  endtask

  task automatic test_async_reset();
    lever = UP;
    tick();
    dn = 3'b000;
    n_checks++;
    if (snap() !== want(GOUP, 2'd0)) begin
      n_fail++; $display("FAIL async_pre_goup: got %h want %h", snap(), want(GOUP, 2'd0));
    end
    #2 Clear = 1'b0;
    #1;
    n_checks++;
    if (snap() !== want(TAXI, 2'd0)) begin
      n_fail++; $display("FAIL async_immediate_taxi: got %h want %h", snap(), want(TAXI, 2'd0));
    end
    ground = 1'b1; dn = 3'b111;
    tick();
    @(negedge Clock);
    Clear = 1'b1;
    tick();
    n_checks++;
    if (snap() !== want(TAXI, 2'd0)) begin
      n_fail++; $display("FAIL async_after_release: got %h want %h", snap(), want(TAXI, 2'd0));
    end
  endtask

  task automatic test_random();
    logic [5:0] r;
    m_state = TAXI; m_cnt = 0; m_code = 2'd0;
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 19) == 0) ground = ~ground;
      if ($urandom_range(0, 7) == 0) lever = ~lever;
      if ($urandom_range(0, 2) == 0) begin
        r = 6'($urandom);
        case ($urandom_range(0, 9))
          0, 1, 2: begin dn = 3'b111; up = 3'b000; end
          3, 4, 5: begin dn = 3'b000; up = 3'b111; end
          6, 7, 8: begin dn = r[2:0]; up = ~r[2:0] & r[5:3]; end
          default: begin dn = r[2:0]; up = r[5:3]; end
        endcase
      end
      ack = ($urandom_range(0, 3) == 0);
      model_step();
      tick();
      n_checks++;
      if (snap() !== want(m_state, m_code)) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h want %h", c, snap(), want(m_state, m_code));
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_extend_land();
    test_reversal();
    test_timeout();
    test_conflict();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
